// File: rtl/instr_refill_ctrl_if.sv
// Miss, memory and line-store signals of the instruction refill engine, named from the engine's side.
// master: the refill engine; slave: the cache/memory environment around it.
interface instr_refill_ctrl_if #(
   parameter int N_CACHELINE_LENGTH = 4,
   parameter int BITSIZE            = 32,
   parameter int ADDR_WIDTH         = 32
);
   logic                                  miss_valid_i;
   logic [ADDR_WIDTH-1:0]                 miss_addr_i;
   logic                                  miss_ready_o;
   logic                                  flush_i;
   logic                                  mem_req_o;
   logic [ADDR_WIDTH-1:0]                 mem_addr_o;
   logic                                  mem_gnt_i;
   logic                                  mem_rvalid_i;
   logic [BITSIZE-1:0]                    mem_rdata_i;
   logic                                  line_valid_o;
   logic [ADDR_WIDTH-1:0]                 line_addr_o;
   logic [BITSIZE*N_CACHELINE_LENGTH-1:0] line_data_o;
   logic                                  busy_o;

   modport master (
      input  miss_valid_i, miss_addr_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output miss_ready_o, mem_req_o, mem_addr_o, line_valid_o, line_addr_o, line_data_o, busy_o
   );

   modport slave (
      output miss_valid_i, miss_addr_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  miss_ready_o, mem_req_o, mem_addr_o, line_valid_o, line_addr_o, line_data_o, busy_o
   );
endinterface

// File: rtl/instr_refill_ctrl.sv
// I-cache refill engine: fetches an aligned line word by word (pipelined, in-order), stores it in one strobe.
// Store strobe N+2 cycles after miss with zero-wait memory; requests held until granted, miss_ready_o low while busy.
module instr_refill_ctrl #(
   parameter int N_CACHELINE_LENGTH = 4,
   parameter int BITSIZE            = 32,
   parameter int ADDR_WIDTH         = 32
) (
   input logic                 clk,
   input logic                 reset_i,
   instr_refill_ctrl_if.master bus
);
   localparam int CW   = $clog2(N_CACHELINE_LENGTH) + 1;
   localparam int IW   = $clog2(N_CACHELINE_LENGTH);
   localparam int LW   = BITSIZE * N_CACHELINE_LENGTH;
   localparam int OFFW = $clog2(N_CACHELINE_LENGTH * BITSIZE / 8);
   localparam logic [CW-1:0]         LINE_WORDS = CW'(N_CACHELINE_LENGTH);
   localparam logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(BITSIZE / 8);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'((64'd1 << OFFW) - 64'd1);

   typedef enum logic [1:0] {IDLE, FETCH, DONE, DRAIN} state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         req_cnt_q, req_cnt_d;
   logic [CW-1:0]         rsp_cnt_q, rsp_cnt_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic                  mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  line_valid_q, line_valid_d;
   logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
   logic [LW-1:0]         line_data_q, line_data_d;
   logic [LW-1:0]         buf_q, buf_d;
   logic                  miss_ready_q, miss_ready_d;
   logic                  busy_q, busy_d;
   logic                  gnt;
   logic                  rsp;

   always_comb begin
      state_d      = state_q;
      req_cnt_d    = req_cnt_q;
      rsp_cnt_d    = rsp_cnt_q;
      base_d       = base_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      line_valid_d = 1'b0;
      line_addr_d  = line_addr_q;
      line_data_d  = line_data_q;
      buf_d        = buf_q;
      miss_ready_d = miss_ready_q;
      busy_d       = busy_q;
      gnt          = mem_req_q & bus.mem_gnt_i;
      // A response with nothing outstanding is spurious and dropped.
      rsp          = bus.mem_rvalid_i & (rsp_cnt_q != req_cnt_q);

      unique case (state_q)
         IDLE: begin
            if (bus.miss_valid_i && miss_ready_q && !bus.flush_i) begin
               base_d       = bus.miss_addr_i & ~OFF_MASK;
               req_cnt_d    = '0;
               rsp_cnt_d    = '0;
               mem_req_d    = 1'b1;
               mem_addr_d   = bus.miss_addr_i & ~OFF_MASK;
               miss_ready_d = 1'b0;
               busy_d       = 1'b1;
               state_d      = FETCH;
            end
         end
         FETCH: begin
            req_cnt_d = req_cnt_q + CW'(gnt);
            rsp_cnt_d = rsp_cnt_q + CW'(rsp);
            for (int k = 0; k < N_CACHELINE_LENGTH; k++) begin
               if (rsp && rsp_cnt_q[IW-1:0] == IW'(k)) begin
                  buf_d[k*BITSIZE +: BITSIZE] = bus.mem_rdata_i;
               end
            end
            if (bus.flush_i) begin
               mem_req_d = 1'b0;
               if (req_cnt_d != rsp_cnt_d) begin
                  state_d = DRAIN;
               end else begin
                  state_d      = IDLE;
                  miss_ready_d = 1'b1;
                  busy_d       = 1'b0;
               end
            end else if (rsp_cnt_d == LINE_WORDS) begin
               mem_req_d    = 1'b0;
               line_valid_d = 1'b1;
               line_addr_d  = base_q;
               line_data_d  = buf_d;
               state_d      = DONE;
            end else if (gnt) begin
               mem_req_d  = (req_cnt_d < LINE_WORDS);
               mem_addr_d = base_q + ADDR_WIDTH'(req_cnt_d) * STRIDE;
            end
         end
         DONE: begin
            state_d      = IDLE;
            miss_ready_d = 1'b1;
            busy_d       = 1'b0;
         end
         DRAIN: begin
            rsp_cnt_d = rsp_cnt_q + CW'(rsp);
            if (rsp_cnt_d == req_cnt_q) begin
               state_d      = IDLE;
               miss_ready_d = 1'b1;
               busy_d       = 1'b0;
            end
         end
         default: begin
            state_d      = IDLE;
            mem_req_d    = 1'b0;
            miss_ready_d = 1'b1;
            busy_d       = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q      <= IDLE;
         req_cnt_q    <= '0;
         rsp_cnt_q    <= '0;
         base_q       <= '0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         line_valid_q <= 1'b0;
         line_addr_q  <= '0;
         line_data_q  <= '0;
         buf_q        <= '0;
         miss_ready_q <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_cnt_q    <= req_cnt_d;
         rsp_cnt_q    <= rsp_cnt_d;
         base_q       <= base_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         line_valid_q <= line_valid_d;
         line_addr_q  <= line_addr_d;
         line_data_q  <= line_data_d;
         buf_q        <= buf_d;
         miss_ready_q <= miss_ready_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.miss_ready_o = miss_ready_q;
   assign bus.mem_req_o    = mem_req_q;
   assign bus.mem_addr_o   = mem_addr_q;
   assign bus.line_valid_o = line_valid_q;
   assign bus.line_addr_o  = line_addr_q;
   assign bus.line_data_o  = line_data_q;
   assign bus.busy_o       = busy_q;
endmodule

// File: doc/instr_refill_ctrl.md
Name: instr_refill_ctrl

Overview:
- Refill engine directly upstream of the instruction cache.
- On an instruction-cache miss it fetches the whole aligned cache line from memory, one word per bus transaction. It assembles the words into a line and presents the line to the cache in a single-cycle store.
- Supports pipelined requests (several outstanding, in-order responses) and flush-abort from the fetch stage.

Parameters:
- N_CACHELINE_LENGTH, 4, words per line; power of two, at least 2.
- BITSIZE, 32, bits per word; multiple of 8. Word stride is BITSIZE/8 bytes.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- miss_valid_i  in  1  miss request from the cache.
- miss_addr_i  in  ADDR_WIDTH  byte address that missed.
- miss_ready_o  out  1  high only in IDLE.
- flush_i  in  1  abort the current refill.
- mem_req_o  out  1  word read request.
- mem_addr_o  out  ADDR_WIDTH  word byte address.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid; responses arrive in request order.
- mem_rdata_i  in  BITSIZE  read data.
- line_valid_o  out  1  one-cycle store strobe to the cache.
- line_addr_o  out  ADDR_WIDTH  line-aligned base address.
- line_data_o  out  BITSIZE*N_CACHELINE_LENGTH  assembled line; word k occupies bits [BITSIZE*k+BITSIZE-1 : BITSIZE*k].
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset: FSM goes to IDLE. Both counters are cleared. line_valid_o, mem_req_o and busy_o are 0; miss_ready_o is 1. line_addr_o and line_data_o are 0. Reset overrides every input in the same cycle, including mid-refill; in-flight responses arriving after reset are ignored.
- State IDLE:
  - On miss_valid_i & miss_ready_o, latch base = miss_addr_i with the low log2(N_CACHELINE_LENGTH*BITSIZE/8) bits cleared.
  - Clear req_cnt and rsp_cnt, then go to FETCH.
  - If flush_i is high in the same cycle, the miss is not accepted and the FSM stays in IDLE.
- State FETCH, requests:
  - mem_req_o = 1 while req_cnt < N_CACHELINE_LENGTH.
  - mem_addr_o = base + req_cnt*(BITSIZE/8).
  - mem_req_o and mem_addr_o are held stable until mem_gnt_i is high; a grant increments req_cnt.
- State FETCH, responses:
  - Each mem_rvalid_i writes mem_rdata_i into line word rsp_cnt, then increments rsp_cnt.
  - mem_rvalid_i is ignored when rsp_cnt equals req_cnt_granted (spurious response).
  - A grant and a response in the same cycle are both processed.
- FETCH exit: when the final response is accepted (rsp_cnt reaches N_CACHELINE_LENGTH), go to DONE.
- State DONE:
  - line_valid_o = 1 for exactly one cycle with line_addr_o = base; then go to IDLE.
  - line_data_o and line_addr_o hold their values until the next refill completes.
- Flush in FETCH:
  - mem_req_o drops the next cycle; no further requests are issued.
  - If responses are outstanding (granted > received), go to DRAIN; otherwise go to IDLE.
  - No line_valid_o is generated for an aborted refill.
- State DRAIN:
  - Discards responses until the granted count equals the received count, then goes to IDLE.
  - miss_ready_o = 0 throughout; flush_i has no further effect.
- Flush in DONE: ignored; the line is already complete and is stored.
- Counter widths: log2(N_CACHELINE_LENGTH)+1 bits. Address addition wraps modulo 2^ADDR_WIDTH.
- Latency with zero-wait memory (gnt in the request cycle, rvalid the next cycle), miss accepted in cycle 0:
  - requests in cycles 1..N;
  - responses in cycles 2..N+1;
  - line_valid_o in cycle N+2;
  - miss_ready_o back to 1 in cycle N+3.

Test Plan:
- Basic refill: miss at 0x0000_1234 with zero-wait memory -> requests to 0x1230, 0x1234, 0x1238, 0x123C in cycles 1-4. line_valid_o in cycle 6 with line_addr_o = 0x1230 and words in index order 0..3.
- Stalled bus: mem_gnt_i held low 3 cycles on the second request -> mem_addr_o stays 0x1234 for those cycles. No duplicate or missing request; line still correct; line_valid_o 3 cycles later than in the basic case.
- Slow responses: rvalid delayed 5 cycles, all 4 requests granted back-to-back -> no more than 4 requests issued. Data lands in the correct slots; single line_valid_o pulse.
- Flush mid-refill: flush_i after 2 grants and 1 response -> enters DRAIN and waits for 1 response. Returns to IDLE with no line_valid_o; the next miss at 0x2000 refills correctly.
- Busy back-pressure: miss_valid_i held high during a refill -> miss_ready_o = 0 until IDLE. The second miss is accepted exactly once, in the cycle after DONE.
- Reset mid-FETCH: reset_i after 1 grant -> next cycle all outputs are at reset values. A late rvalid is ignored; a subsequent refill is correct.
